// File: rtl/seq_shift_add_mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier.
package seq_shift_add_mult_pkg;

    localparam int DEFAULT_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/seq_shift_add_mult_adder.sv
// WIDTH-bit ripple-carry adder built from chained 1-bit full-adder cells, carry-in tied low.
module wbit_ripple_adder #(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             Cout
);

    logic [WIDTH:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign S[i]       = A[i] ^ B[i] ^ carry[i];
        assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
    end

    assign Cout = carry[WIDTH];

endmodule

// File: rtl/seq_shift_add_mult.sv
// Sequential unsigned shift-and-add multiplier, WIDTH x WIDTH -> 2*WIDTH, start/busy/done handshake.
module seq_shift_add_mult
    import seq_shift_add_mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] P
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   q_q, q_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] p_q, p_d;

    logic [WIDTH-1:0]   sum;
    logic               cout;
    logic               c;
    logic [WIDTH-1:0]   acc_n;

    wbit_ripple_adder #(.WIDTH(WIDTH)) u_adder (
        .A    (acc_q),
        .B    (m_q),
        .S    (sum),
        .Cout (cout)
    );

    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        cnt_d   = cnt_q;
        p_d     = p_q;
        c       = 1'b0;
        acc_n   = acc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    m_d     = A;
                    q_d     = B;
                    acc_d   = '0;
                    cnt_d   = CW'(WIDTH);
                    state_d = ST_CALC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                {c, acc_n} = q_q[0] ? {cout, sum} : {1'b0, acc_q};
                // Carry lands in the ACC MSB so the adder overflow is never dropped.
                acc_d = {c, acc_n[WIDTH-1:1]};
                q_d   = {acc_n[0], q_q[WIDTH-1:1]};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = ST_DONE;
                    p_d     = {acc_d, q_d};
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            cnt_q   <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            cnt_q   <= cnt_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q == ST_CALC);
    assign done = (state_q == ST_DONE);
    assign P    = p_q;

endmodule
